// File: rtl/common.sv
// Shared typedefs for the core pipeline and its program loader.
package common;

  typedef logic [31:0] instr_t;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DRAIN,
    LD_RUN,
    LD_ERROR
  } loader_state_type;

endpackage

// File: rtl/program_loader.sv
// Streams a program into instruction memory, holds the core in reset while
// loading, and releases it a fixed number of cycles after the final write.
module program_loader
  import common::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int RUN_DELAY  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  instr_t                load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output instr_t                mem_write_data,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] word_count
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int WCW   = ADDR_WIDTH - 1;
  localparam int DCW   = $clog2(RUN_DELAY + 1) + 1;

  loader_state_type state;
  logic [DCW-1:0]   drain_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= LD_IDLE;
      load_ready       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      cpu_reset_n      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      word_count       <= '0;
      drain_count      <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      case (state)
        LD_IDLE: begin
          if (load_start) begin
            state      <= LD_LOAD;
            load_ready <= 1'b1;
            busy       <= 1'b1;
            word_count <= '0;
          end
        end
        // load_ready is always 1 here, so load_valid alone marks a handshake
        LD_LOAD: begin
          if (load_valid) begin
            mem_write_enable <= 1'b1;
            mem_address      <= {word_count[ADDR_WIDTH-3:0], 2'b00};
            mem_write_data   <= load_data;
            if (word_count != WCW'(DEPTH))
              word_count <= word_count + 1'b1;
            if (load_last) begin
              state       <= LD_DRAIN;
              load_ready  <= 1'b0;
              drain_count <= '0;
            end else if (word_count == WCW'(DEPTH - 1)) begin
              state      <= LD_ERROR;
              load_ready <= 1'b0;
              busy       <= 1'b0;
              error      <= 1'b1;
            end
          end
        end
        LD_DRAIN: begin
          if (drain_count == DCW'(RUN_DELAY)) begin
            state       <= LD_RUN;
            busy        <= 1'b0;
            done        <= 1'b1;
            cpu_reset_n <= 1'b1;
          end else begin
            drain_count <= drain_count + 1'b1;
          end
        end
        LD_RUN, LD_ERROR: begin
          if (load_start) begin
            state       <= LD_LOAD;
            load_ready  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
            word_count  <= '0;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule
